// File: rtl/rv32i_types.sv
// Shared types for the data-side cache responder.
//   dcache_state_t : controller states
//   LINE_BITS      : width of one cache line / physical-memory beat
package rv32i_types;

  localparam int LINE_BITS = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } dcache_state_t;

endpackage

// File: rtl/dcache_datapath.sv
// Direct-mapped cache storage: per-set valid/dirty/tag/line flops, hit
// compare, store byte-merge and load word select.
//   address/byte_enable/wdata : CPU request fields
//   write_hit                 : merge store bytes into the selected line
//   load_line                 : install line_in with the request tag (fill)
//   clear_dirty               : victim has been written back
//   hit, valid_sel, dirty_sel, tag_sel, line_sel : state of the indexed set
//   rdata                     : selected word of the indexed line
module dcache_datapath
  import rv32i_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          address,
  input  logic [3:0]           byte_enable,
  input  logic [31:0]          wdata,
  input  logic                 write_hit,
  input  logic                 load_line,
  input  logic                 clear_dirty,
  input  logic [LINE_BITS-1:0] line_in,
  output logic                 hit,
  output logic                 valid_sel,
  output logic                 dirty_sel,
  output logic [26-S_INDEX:0]  tag_sel,
  output logic [LINE_BITS-1:0] line_sel,
  output logic [31:0]          rdata
);

  localparam int SETS  = 2 ** S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  logic [S_INDEX-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic [2:0]           wsel;
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];
  logic [LINE_BITS-1:0] merged;

  assign idx  = address[4+S_INDEX:5];
  assign tag  = address[31:5+S_INDEX];
  assign wsel = address[4:2];

  assign valid_sel = valid_q[idx];
  assign dirty_sel = dirty_q[idx];
  assign tag_sel   = tag_q[idx];
  assign line_sel  = data_q[idx];
  assign hit       = valid_sel && (tag_sel == tag);
  assign rdata     = line_sel[{wsel, 5'b00000} +: 32];

  always_comb begin
    merged = line_sel;
    for (int b = 0; b < 4; b++) begin
      if (byte_enable[b]) merged[{wsel, b[1:0], 3'b000} +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_line) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else begin
      if (clear_dirty) dirty_q[idx] <= 1'b0;
      // an all-zero mask changes nothing, so the line stays clean
      if (write_hit && (byte_enable != 4'b0000)) dirty_q[idx] <= 1'b1;
    end
  end

  // tag and data contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (load_line) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= line_in;
    end else if (write_hit) begin
      data_q[idx] <= merged;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Data-side responder for the MEM-stage load/store port. Direct-mapped,
// write-back, write-allocate cache with 32-byte lines; misses go out over a
// 256-bit line interface.
//   mem_*  : CPU word port (request held until mem_resp)
//   pmem_* : physical memory line port (request held until pmem_resp)
//
// state     | meaning
// IDLE      | compare tag; hit answers this cycle, miss picks WRITEBACK/FILL
// WRITEBACK | victim line out on pmem_write until pmem_resp
// FILL      | requested line in on pmem_read until pmem_resp
module dcache_responder
  import rv32i_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_address,
  input  logic [31:0]          mem_wdata,
  output logic                 mem_resp,
  output logic [31:0]          mem_rdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  dcache_state_t state, state_next;

  logic [S_INDEX-1:0]  idx;
  logic [26-S_INDEX:0] req_tag;
  logic [26-S_INDEX:0] tag_sel;
  logic                req, hit, valid_sel, dirty_sel;
  logic                write_hit, load_line, clear_dirty;

  assign idx     = mem_address[4+S_INDEX:5];
  assign req_tag = mem_address[31:5+S_INDEX];
  assign req     = mem_read | mem_write;

  dcache_datapath #(.S_INDEX(S_INDEX)) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .address     (mem_address),
    .byte_enable (mem_byte_enable),
    .wdata       (mem_wdata),
    .write_hit   (write_hit),
    .load_line   (load_line),
    .clear_dirty (clear_dirty),
    .line_in     (pmem_rdata),
    .hit         (hit),
    .valid_sel   (valid_sel),
    .dirty_sel   (dirty_sel),
    .tag_sel     (tag_sel),
    .line_sel    (pmem_wdata),
    .rdata       (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // pmem requests decode straight from state, so reset drops them at once
  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    write_hit    = 1'b0;
    load_line    = 1'b0;
    clear_dirty  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            write_hit = mem_write;
          end else if (valid_sel && dirty_sel) begin
            state_next = WRITEBACK;
          end else begin
            state_next = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_sel, idx, 5'b00000};
        if (pmem_resp) begin
          clear_dirty = 1'b1;
          state_next  = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, 5'b00000};
        if (pmem_resp) begin
          load_line  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;

  logic         clk;
  logic         reset;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  dcache_responder dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           lat;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: cache contents and backing memory, keyed by line number
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [23:0]  m_tag   [8];
  logic [255:0] m_data  [8];
  logic [255:0] mem_model [logic [26:0]];

  txn_t         txq[$];
  logic [31:0]  last_rdata;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] get_line(input logic [26:0] ln);
    logic [255:0] l;
    if (mem_model.exists(ln)) return mem_model[ln];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'(ln) * 32'h9E37_79B9 + 32'(w) * 32'h0101_0101;
    return l;
  endfunction

  task automatic do_req(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input int fixed_lat);
    int cyc, cnt, exp_cyc, lat_sum;
    bit done, active, m_hit;
    logic [2:0]   idx;
    logic [23:0]  tg;
    txn_t         exp_q[$];
    logic [31:0]  word;
    cyc = 0; cnt = 0; done = 0; active = 0; lat_sum = 0;
    txq.delete();
    mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = addr; mem_wdata = wd;
    while (!done && cyc < 400) begin
      #1;
      chk("pmem_excl", {255'd0, pmem_read & pmem_write}, 256'd0);
      if (mem_resp) begin
        done = 1;
        last_rdata = mem_rdata;
        chk("resp_no_pmem", {255'd0, pmem_read | pmem_write}, 256'd0);
      end else if (pmem_read || pmem_write) begin
        if (!active) begin
          active = 1;
          cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          txq.push_back('{wr: pmem_write, addr: pmem_address, data: pmem_wdata, lat: cnt});
        end
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          if (pmem_write) mem_model[pmem_address[31:5]] = pmem_wdata;
          else pmem_rdata = get_line(pmem_address[31:5]);
          active = 0;
        end else begin
          cnt--;
        end
      end
      @(posedge clk);
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!done) cyc++;
    end
    chk("resp_timeout", {255'd0, done}, {255'd0, 1'b1});
    mem_read = 1'b0; mem_write = 1'b0;

    idx = addr[7:5];
    tg  = addr[31:8];
    m_hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!m_hit) begin
      if (m_valid[idx] && m_dirty[idx])
        exp_q.push_back('{wr: 1'b1, addr: {m_tag[idx], idx, 5'd0}, data: m_data[idx], lat: 0});
      exp_q.push_back('{wr: 1'b0, addr: {tg, idx, 5'd0}, data: '0, lat: 0});
    end
    chk("txn_count", 256'(txq.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      chk("txn_kind", {255'd0, txq[i].wr}, {255'd0, exp_q[i].wr});
      chk("txn_addr", {224'd0, txq[i].addr}, {224'd0, exp_q[i].addr});
      if (exp_q[i].wr) chk("txn_wdata", txq[i].data, exp_q[i].data);
      lat_sum += txq[i].lat + 1;
    end
    exp_cyc = m_hit ? 0 : 1 + lat_sum;
    chk("latency", 256'(cyc), 256'(exp_cyc));

    if (!m_hit) begin
      m_data[idx]  = get_line({tg, idx});
      m_tag[idx]   = tg;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
    end
    word = m_data[idx][addr[4:2]*32 +: 32];
    if (rd) chk("rdata", {224'd0, last_rdata}, {224'd0, word});
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) word[b*8 +: 8] = wd[b*8 +: 8];
      m_data[idx][addr[4:2]*32 +: 32] = word;
      if (be != 4'b0000) m_dirty[idx] = 1;
    end
  endtask

  task automatic reset_during_fill(input logic [31:0] addr);
    int n;
    n = 0;
    mem_read = 1'b1; mem_address = addr; mem_byte_enable = 4'b0000;
    #1;
    while (!pmem_read && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("fill_seen", {255'd0, pmem_read}, {255'd0, 1'b1});
    reset = 1'b1;
    #1;
    chk("rst_pmem_read", {255'd0, pmem_read}, 256'd0);
    chk("rst_pmem_write", {255'd0, pmem_write}, 256'd0);
    chk("rst_mem_resp", {255'd0, mem_resp}, 256'd0);
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    @(negedge clk);
    reset = 1'b0;
    mem_read = 1'b0;
    pmem_rdata = {8{32'h0BAD_0BAD}};
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("late_resp_idle", {254'd0, pmem_read, pmem_write}, 256'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] l;
    reset = 1'b1;
    mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    pmem_rdata = '0; pmem_resp = 0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h1111_0000 + 32'(w);
    l[63:32] = 32'hDEAD_BEEF;
    mem_model[27'h2] = l;

    @(negedge clk);
    #1;
    chk("reset_mem_resp", {255'd0, mem_resp}, 256'd0);
    chk("reset_pmem_read", {255'd0, pmem_read}, 256'd0);
    chk("reset_pmem_write", {255'd0, pmem_write}, 256'd0);
    chk("reset_pmem_addr", {224'd0, pmem_address}, 256'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_req(1, 0, 4'hF, 32'h0000_0044, 0, 3);
    chk("cold_rdata", {224'd0, last_rdata}, {224'd0, 32'hDEAD_BEEF});
    do_req(1, 0, 4'hF, 32'h0000_0044, 0, -1);
    do_req(0, 1, 4'b0110, 32'h0000_0044, 32'hAABB_CCDD, -1);
    do_req(1, 0, 4'hF, 32'h0000_0044, 0, -1);
    chk("merged_word", {224'd0, last_rdata}, {224'd0, 32'hDEBB_CCEF});
    do_req(1, 0, 4'hF, 32'h0000_0144, 0, 2);
    chk("victim_first", {255'd0, (txq.size() > 0) ? txq[0].wr : 1'b0}, {255'd0, 1'b1});
    chk("victim_word1", {224'd0, (txq.size() > 0) ? txq[0].data[63:32] : 32'd0}, {224'd0, 32'hDEBB_CCEF});
    do_req(0, 1, 4'b0000, 32'h0000_0144, 32'h1234_5678, -1);
    do_req(1, 0, 4'hF, 32'h0000_0044, 0, -1);
    chk("mask0_no_wb", 256'(txq.size()), 256'd1);

    reset_during_fill(32'h0000_0064);
    do_req(1, 0, 4'hF, 32'h0000_0064, 0, -1);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic        w;
      a = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 2'b00};
      w = 1'($urandom);
      do_req(!w, w, ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom), a, $urandom, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side responder for the MEM stage's load/store port.
- Accepts word requests (read/write, byte mask, address, write data) and answers with a single-cycle resp plus read data.
- Backed by a direct-mapped, write-back, write-allocate cache with 32-byte lines.
- Misses are serviced over a 256-bit line interface to physical memory / arbiter.

Parameters:
- S_INDEX, 3, index bits; number of sets = 2**S_INDEX (8 sets). Tag width = 27 - S_INDEX.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU load request; held until mem_resp
- mem_write  in  1  CPU store request; held until mem_resp
- mem_byte_enable  in  4  store byte mask (bit i = byte i of word)
- mem_address  in  32  byte address; bits [1:0] ignored for line/word select
- mem_wdata  in  32  store data, lane-aligned
- mem_resp  out  1  request complete this cycle
- mem_rdata  out  32  selected word of hit line; valid when mem_resp && mem_read
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  32  line-aligned address (bits [4:0] = 0)
- pmem_wdata  out  256  victim line data
- pmem_rdata  in  256  fill line data, valid with pmem_resp
- pmem_resp  in  1  physical memory transaction done

Behaviour:
- Address split: offset [4:0], word select [4:2], index [4+S_INDEX:5], tag [31:5+S_INDEX].
- Storage is flop-based per set: valid, dirty, tag, and 256-bit data.
- Reset clears valid and dirty for all sets and puts the FSM in IDLE. Tag/data arrays are not reset.
- Outputs at reset: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata = don't-care.
- Reset mid-transaction:
  - FSM returns to IDLE and pmem_read/pmem_write drop immediately.
  - A late pmem_resp is ignored.
- FSM states: IDLE (compare), WRITEBACK, FILL.
- IDLE:
  - req = mem_read | mem_write.
  - hit = valid[idx] && tag[idx]==req tag.
  - req && hit:
    - mem_resp=1 combinationally in the same cycle.
    - mem_rdata = word[wsel] of the line, combinational.
    - On a write, masked bytes are merged into the line at the clock edge. Dirty is set only if mem_byte_enable != 0.
    - Stay in IDLE.
  - req && !hit && valid && dirty: go to WRITEBACK.
  - req && !hit && !(valid && dirty): go to FILL.
  - !req: no state change; mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_address={tag[idx], idx, 5'b0}, pmem_wdata=data[idx].
  - On pmem_resp: clear dirty[idx] and go to FILL.
- FILL:
  - pmem_read=1, pmem_address={req tag, idx, 5'b0}.
  - On pmem_resp: write pmem_rdata to data[idx], set tag, valid=1, dirty=0, then go to IDLE.
  - The next cycle hits, so the miss latency is fill time + 1 cycle.
- Latency:
  - Hit: 0 extra cycles (resp in the request cycle).
  - Clean miss: pmem latency + 1 cycle.
  - Dirty miss: writeback + fill + 1 cycle.
- mem_resp is never asserted outside IDLE.
- pmem_read and pmem_write are never both high.
- Simultaneous mem_read and mem_write is illegal. If it occurs, the write is performed and rdata is still driven.
- Requests must stay stable until mem_resp. A request change mid-miss is unsupported; the FSM completes the fill for the original index.
- The responder never de-asserts a pmem request before pmem_resp.

Decomposition:
- Shared package rv32i_types: dcache_state_t enum {IDLE, WRITEBACK, FILL} and a line-width constant (256).
- The address split stays local to the module.
- One natural sub-module: dcache_datapath, holding the arrays, hit compare, byte-merge, and word select.
- The FSM lives in dcache_responder and drives load/select controls into the datapath.

Test Plan:
- Cold read 0x0000_0044, pmem returns a line with word1=0xDEADBEEF after 3 cycles:
  - pmem_read with pmem_address=0x40.
  - mem_resp one cycle after pmem_resp.
  - mem_rdata=0xDEADBEEF.
- Read again at 0x0000_0044 → mem_resp the same cycle, no pmem activity.
- Write 0xAABBCCDD, mask 4'b0110 to 0x44 (word was 0xDEADBEEF) → resp same cycle; a subsequent read returns 0xDEBBCCEF.
- Read 0x0000_0144 (same index, new tag) after the dirty write:
  - pmem_write first, with address 0x40 and the victim data containing 0xDEBBCCEF at word1.
  - Then pmem_read with address 0x140.
  - Then resp.
- Write with mask 4'b0000 on a hit line, then force eviction → no pmem_write (dirty not set).
- Assert reset during FILL while pmem_read=1 → pmem_read drops immediately; the following read to the same address misses again.
